led_blink_array: RTL and testbench
==================================

# led_blink_array

Multi-channel, run-time configurable LED driver that generalises the single fixed 0.5 s blinker. One shared prescaler derives a millisecond-class tick from the system clock. Each of N_CH channels independently runs OFF, ON, BLINK (programmable half-period) or ONESHOT (timed pulse) mode. It sits between the board clock and the LED pins, and is configured by a simple single-cycle write port from control logic or switches.

## Interface
- CLK_HZ, 125_000_000: input clock frequency.
- TICK_HZ, 1000: tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- N_CH, 4: number of LED channels, 1..16.
- PER_W, 12: width of half-period / pulse-length field, in ticks.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel.
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
- cfg_half  in  PER_W  BLINK half-period or ONESHOT length, in ticks.
- led  out  N_CH  registered LED drive, 1 = lit.
- busy  out  N_CH  1 while channel is in ONESHOT and not yet expired.
- tick  out  1  one-cycle prescaler pulse, exported for debug and sync.

## Operation
- Reset values: led = 0, busy = 0, tick = 0, all modes OFF, all channel counters 0, prescaler 0.
- Prescaler: counts 0..DIV-1 and wraps. tick = 1 on the cycle the count equals DIV-1. It is free-running and is never reset by config writes.
- Per channel state: mode[1:0], half[PER_W-1:0], cnt[PER_W-1:0], led bit.
- A cfg_half value of 0 is treated as 1.
- Write (cfg_we = 1, cfg_ch < N_CH) latches mode and half, and clears cnt. The next cycle's outputs are:
  - OFF: led 0, busy 0.
  - ON: led 1, busy 0.
  - BLINK: led 1, busy 0.
  - ONESHOT: led 1, busy 1.
- Writes with cfg_ch ≥ N_CH are ignored.
- BLINK: on each tick, if cnt == half-1 then led toggles and cnt ← 0; otherwise cnt ← cnt+1. The result is a square wave with period 2·half ticks and 50 % duty.
- ONESHOT: on each tick, if cnt == half-1 then led ← 0, busy ← 0, mode ← OFF; otherwise cnt ← cnt+1.
- OFF and ON ignore tick; cnt is held.
- Simultaneous write and tick on the same channel: the write wins and that tick is not counted for that channel. Other channels process the tick normally.
- A rewrite of the same channel mid-BLINK or mid-ONESHOT restarts it from the write rules above, including re-arming a ONESHOT.
- Counter width: cnt compares against half-1 within PER_W bits. With half = 2^PER_W − 1 the channel never overflows.

## Timing
- Write to led/busy update: 1 cycle, registered.
- First BLINK toggle or ONESHOT expiry occurs after exactly `half` ticks not coincident with the write cycle. In clocks this is between (half−1)·DIV+1 and half·DIV cycles after the write, depending on prescaler phase.
- A toggle or expiry is visible on led 1 cycle after the tick cycle.
- rst_n assertion at any time clears all state immediately, with no clock required. Deassertion is expected to be synchronous to clk, handled externally.

## Structure
- Shared package led_blink_pkg holds:
  - mode localparams MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2, MODE_ONESHOT = 2'd3;
  - a DIV computation function;
  - a clog2 helper.
- Sub-module tick_gen (params CLK_HZ, TICK_HZ; ports clk, rst_n, tick) contains the prescaler. It is instantiated once.
- Channels are built with a generate loop in the top. No per-channel sub-module is required.

## Test plan
All scenarios use CLK_HZ = 1000, TICK_HZ = 100 (DIV = 10), N_CH = 4, PER_W = 4.

1. Reset check: hold rst_n low, then release. Required: led = 4'b0000, busy = 0, and tick pulses every 10 cycles. Then assert rst_n mid-blink; led clears the same cycle.
2. BLINK basic: write ch1 BLINK, half = 3. Required: led[1] = 1 next cycle, then toggles every 3 ticks (30 clocks) with 60-clock period. Other channels stay 0.
3. ONESHOT: write ch2 ONESHOT, half = 5. Required: led[2] = busy[2] = 1 for 5 ticks, then both 0, and they stay 0 through 20 more ticks. A re-write while busy restarts the full 5-tick count.
4. Boundary values:
   - half = 0 behaves as half = 1, toggling every tick.
   - half = 15 gives a 300-clock period with no wrap error.
   - cfg_ch = 3 with ON drives led[3] = 1.
5. Write on tick cycle: write ch0 BLINK, half = 2 on a tick cycle. Required: that tick is not counted, so the first toggle is 2 later ticks after it. Ch1 in BLINK on the same tick still toggles on schedule.
6. Mode change: switch ch1 from BLINK (led currently 0) to ON. Required: led[1] = 1 next cycle and no further toggles. Then switch to OFF; led[1] = 0 next cycle.

Source files
------------

// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_pkg
//  Description : Shared mode encodings and elaboration helpers for the
//                multi-channel LED driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    // Clock cycles per tick; the caller must choose an exact divisor >= 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bit width needed to index v items, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_array_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-cycle tick every
//                CLK_HZ/TICK_HZ clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ  = 125_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             c_DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int             c_CW   = clog2_min1(c_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_blink_array.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_array
//  Description : N_CH independent LED channels (OFF/ON/BLINK/ONESHOT) sharing
//                one prescaler tick, configured through a single-cycle write.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ  = 125_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int PER_W   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [clog2_min1(N_CH)-1:0]   cfg_ch,
    input  logic [1:0]                    cfg_mode,
    input  logic [PER_W-1:0]              cfg_half,
    output logic [N_CH-1:0]               led,
    output logic [N_CH-1:0]               busy,
    output logic                          tick
);

    localparam int c_CHW = clog2_min1(N_CH);

    logic             w_tick;
    logic [PER_W-1:0] w_half_in;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign tick      = w_tick;
    assign w_half_in = (cfg_half == '0) ? PER_W'(1) : cfg_half;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            logic [1:0]       r_mode;
            logic [PER_W-1:0] r_half;
            logic [PER_W-1:0] r_cnt;
            logic             r_led;
            logic             w_wr;
            logic             w_hit;

            // Channel indices beyond N_CH never match, so such writes drop.
            assign w_wr  = cfg_we && (cfg_ch == c_CHW'(g));
            assign w_hit = (r_cnt == (r_half - PER_W'(1)));

            // A write takes priority over a coincident tick for this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mode <= MODE_OFF;
                    r_half <= '0;
                    r_cnt  <= '0;
                    r_led  <= 1'b0;
                end else if (w_wr) begin
                    r_mode <= cfg_mode;
                    r_half <= w_half_in;
                    r_cnt  <= '0;
                    r_led  <= (cfg_mode != MODE_OFF);
                end else if (w_tick) begin
                    case (r_mode)
                        MODE_BLINK: begin
                            if (w_hit) begin
                                r_led <= ~r_led;
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + PER_W'(1);
                            end
                        end
                        MODE_ONESHOT: begin
                            if (w_hit) begin
                                r_led  <= 1'b0;
                                r_mode <= MODE_OFF;
                                r_cnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt + PER_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            assign led[g]  = r_led;
            assign busy[g] = (r_mode == MODE_ONESHOT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_blink_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_array
//  Description : Scoreboard bench for led_blink_array (DIV = 10, 4 channels).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_array;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int N_CH    = 4;
    localparam int PER_W   = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    typedef struct {
        logic [N_CH-1:0] led;
        logic [N_CH-1:0] busy;
        logic            tick;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PER_W-1:0] cfg_half;
    logic [N_CH-1:0]  led;
    logic [N_CH-1:0]  busy;
    logic             tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Spec-level reference: ticks elapsed since the last write per channel.
    int   m_mode  [N_CH];
    int   m_half  [N_CH];
    int   m_ticks [N_CH];
    int   m_pc;
    exp_t sb_q[$];

    led_blink_array #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .N_CH    (N_CH),
        .PER_W   (PER_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .led      (led),
        .busy     (busy),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c]  = 0;
            m_half[c]  = 1;
            m_ticks[c] = 0;
        end
        m_pc = 0;
    endtask

    function automatic logic exp_led(input int c);
        case (m_mode[c])
            1:       return 1'b1;
            2:       return ((m_ticks[c] / m_half[c]) % 2) == 0;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
    task automatic cycle(input logic we, input int ch, input logic [1:0] m, input int h);
        exp_t e;
        exp_t got;
        logic tick_now;
        cfg_we   = we;
        cfg_ch   = 2'(ch);
        cfg_mode = m;
        cfg_half = PER_W'(h);
        tick_now = (m_pc == DIV - 1);
        for (int c = 0; c < N_CH; c++) begin
            if (we && ch == c) begin
                m_mode[c]  = int'(m);
                m_half[c]  = (h == 0) ? 1 : h;
                m_ticks[c] = 0;
            end else if (tick_now && m_mode[c] >= 2) begin
                m_ticks[c]++;
                if (m_mode[c] == 3 && m_ticks[c] >= m_half[c]) m_mode[c] = 0;
            end
        end
        m_pc = (m_pc + 1) % DIV;
        for (int c = 0; c < N_CH; c++) begin
            e.led[c]  = exp_led(c);
            e.busy[c] = (m_mode[c] == 3);
        end
        e.tick = (m_pc == DIV - 1);
        sb_q.push_back(e);
        @(negedge clk);
        cfg_we = 1'b0;
        got = sb_q.pop_front();
        check_eq("led",  32'(led),  32'(got.led));
        check_eq("busy", 32'(busy), 32'(got.busy));
        check_eq("tick", 32'(tick), 32'(got.tick));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 2'd0, 0);
    endtask

    task automatic wr(input int ch, input logic [1:0] m, input int h);
        cycle(1'b1, ch, m, h);
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_half = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_led",  32'(led),  32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;

        // Prescaler alone, then a basic blink on ch1.
        idle(25);
        wr(1, 2'd2, 3);
        idle(130);

        // Asynchronous reset mid-blink clears outputs without a clock edge.
        wr(3, 2'd1, 0);
        idle(7);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_led",  32'(led),  32'h0);
        check_eq("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3);

        // One-shot, re-armed while busy, then long quiet period.
        wr(2, 2'd3, 5);
        idle(30);
        wr(2, 2'd3, 5);
        idle(60);
        idle(200);

        // Boundary half-periods and highest channel.
        wr(0, 2'd2, 0);
        idle(40);
        wr(0, 2'd2, 15);
        idle(320);
        wr(3, 2'd1, 7);
        idle(3);

        // Write coinciding with a tick while another channel keeps blinking.
        wr(1, 2'd2, 2);
        idle(3);
        while (m_pc != DIV - 1) idle(1);
        wr(0, 2'd2, 2);
        idle(60);

        // Mode change from BLINK (led low) to ON, then OFF.
        for (int i = 0; i < 100 && exp_led(1); i++) idle(1);
        check_eq("ch1_low_before_on", 32'(led[1]), 32'h0);
        wr(1, 2'd1, 2);
        idle(40);
        wr(1, 2'd0, 2);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
